// File: rtl/nibble_addsub.sv
// Multi-cycle adder/subtractor: processes one 4-bit slice per clock through a
// carry-lookahead slice adder, producing S, unsigned carry-out and signed overflow.
module nibble_addsub #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4*NIB-1:0] A,
  input  logic [4*NIB-1:0] B,
  input  logic             Sub,
  output logic [4*NIB-1:0] S,
  output logic             Cout,
  output logic             Ofl,
  output logic             busy,
  output logic             done
);

  localparam int W  = 4 * NIB;
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_r, b_r, s_r;
  logic          carry, cout_r, ofl_r;
  logic [CW-1:0] cnt;
  logic          accept, last;
  logic [3:0]    an, bn, g, p, sum;
  logic [4:0]    c;

  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(NIB - 1));
  assign an     = a_r[{cnt, 2'b00} +: 4];
  assign bn     = b_r[{cnt, 2'b00} +: 4];

  // Lookahead carries are expanded from generate/propagate so no carry ripples
  // through the slice.
  always_comb begin
    g    = an & bn;
    p    = an ^ bn;
    c[0] = carry;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum  = p ^ c[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is folded into the operand latch: B is inverted and the
  // initial carry supplies the +1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_r <= 1'b0;
      ofl_r  <= 1'b0;
    end else if (accept) begin
      a_r    <= A;
      b_r    <= B ^ {W{Sub}};
      carry  <= Sub;
      cnt    <= '0;
      s_r    <= '0;
      cout_r <= 1'b0;
      ofl_r  <= 1'b0;
    end else if (state == RUN) begin
      s_r[{cnt, 2'b00} +: 4] <= sum;
      carry <= c[4];
      cnt   <= cnt + 1'b1;
      if (last) begin
        cout_r <= c[4];
        ofl_r  <= c[3] ^ c[4];
      end
    end
  end

  assign S    = s_r;
  assign Cout = cout_r;
  assign Ofl  = ofl_r;
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_addsub.sv
// Self-checking bench for nibble_addsub (NIB=4): directed corner cases, back-to-back
// operation, mid-run reset and randomized operands against an arithmetic model.
module tb_nibble_addsub;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A, B;
  logic        Sub;
  logic [15:0] S;
  logic        Cout, Ofl, busy, done;

  int numCompared;
  int numMismatched;

  nibble_addsub #(.NIB(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Sub(Sub),
    .S(S), .Cout(Cout), .Ofl(Ofl), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, observed, expected);
    end
  endtask

  // Reference: {Ofl, Cout, S} from plain integer arithmetic.
  function automatic logic [17:0] refModel(input logic [15:0] a, input logic [15:0] b,
                                           input logic sub);
    int sa, sb, r;
    logic [15:0] s;
    logic co, of;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = sub ? sa - sb : sa + sb;
    of = (r > 32767) || (r < -32768);
    co = sub ? (int'(a) >= int'(b)) : ((int'(a) + int'(b)) > 65535);
    s  = sub ? a - b : a + b;
    return {of, co, s};
  endfunction

  task automatic checkResult(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic sub);
    logic [17:0] exp;
    exp = refModel(a, b, sub);
    checkOutput($sformatf("%s A=%h B=%h sub=%0d S", name, a, b, sub), 32'(S), 32'(exp[15:0]));
    checkOutput($sformatf("%s A=%h B=%h Cout", name, a, b), 32'(Cout), 32'(exp[16]));
    checkOutput($sformatf("%s A=%h B=%h Ofl", name, a, b), 32'(Ofl), 32'(exp[17]));
  endtask

  // One operation with operands scrambled after acceptance; checks latency,
  // busy length, result, single-cycle done and result hold.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sub,
                               input string name);
    int   edges, busyCycles;
    bit   gotDone;
    logic [17:0] exp;
    exp = refModel(a, b, sub);
    @(negedge clk);
    A = a; B = b; Sub = sub; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; A = 16'($urandom); B = 16'($urandom); Sub = ~sub;
    busyCycles = busy ? 1 : 0;
    edges      = 1;
    gotDone    = 1'b0;
    for (int i = 0; i < 20 && !gotDone; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      A = 16'($urandom); B = 16'($urandom);
      if (done) gotDone = 1'b1;
      else if (busy) busyCycles++;
    end
    checkOutput({name, " done_seen"}, 32'(gotDone), 32'd1);
    checkOutput({name, " done_edge"}, 32'(edges), 32'd5);
    checkOutput({name, " busy_cycles"}, 32'(busyCycles), 32'd4);
    checkOutput({name, " busy_in_done"}, 32'(busy), 32'd0);
    checkResult(name, a, b, sub);
    @(negedge clk);
    checkOutput({name, " done_one_cycle"}, 32'(done), 32'd0);
    checkOutput({name, " S_hold"}, 32'(S), 32'(exp[15:0]));
  endtask

  initial begin
    logic [15:0] a1, b1, a2, b2, ra, rb;
    logic        rs;
    bit          gotDone;
    int          doneSeen;

    numCompared = 0;
    numMismatched = 0;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Sub = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset S", 32'(S), 32'd0);
    checkOutput("reset Cout", 32'(Cout), 32'd0);
    checkOutput("reset Ofl", 32'(Ofl), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    rst = 1'b0;

    applyStimulus(16'h0001, 16'h000F, 1'b0, "add_1_F");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, "add_wrap");
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, "add_ofl");
    applyStimulus(16'h0005, 16'h0007, 1'b1, "sub_borrow");
    applyStimulus(16'h8000, 16'h0001, 1'b1, "sub_ofl");
    applyStimulus(16'h1234, 16'h1234, 1'b1, "sub_equal");

    // Back-to-back: start held high throughout, operands churned during RUN.
    a1 = 16'h3A5C; b1 = 16'h4F91; a2 = 16'h0100; b2 = 16'h0FFF;
    @(negedge clk);
    A = a1; B = b1; Sub = 1'b0; start = 1'b1;
    @(posedge clk);
    gotDone = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin gotDone = 1'b1; break; end
      A = 16'($urandom); B = 16'($urandom); Sub = 1'($urandom);
    end
    checkOutput("b2b first done_seen", 32'(gotDone), 32'd1);
    checkResult("b2b first", a1, b1, 1'b0);
    A = a2; B = b2; Sub = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b busy_after_done", 32'(busy), 32'd1);
    checkOutput("b2b done_low", 32'(done), 32'd0);
    start = 1'b0;
    gotDone = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin gotDone = 1'b1; break; end
    end
    checkOutput("b2b second done_seen", 32'(gotDone), 32'd1);
    checkResult("b2b second", a2, b2, 1'b1);

    // Reset asserted during the second RUN cycle.
    @(negedge clk);
    A = 16'h0003; B = 16'h0004; Sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid busy", 32'(busy), 32'd0);
    checkOutput("rst_mid done", 32'(done), 32'd0);
    checkOutput("rst_mid S", 32'(S), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("rst_mid no_done", 32'(doneSeen), 32'd0);

    // Start presented right as reset releases is taken on the very next edge.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; A = 16'h0010; B = 16'h0020; Sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("rst_release first_start", 32'(busy), 32'd1);
    gotDone = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin gotDone = 1'b1; break; end
    end
    checkOutput("rst_release done_seen", 32'(gotDone), 32'd1);
    checkResult("rst_release", 16'h0010, 16'h0020, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      applyStimulus(ra, rb, rs, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
